// File: rtl/ps2_kbd_ctrl.sv
// PS/2 scan-code sequencer: folds E0/F0 prefixes into key events,
// queues them in a small FWFT FIFO and tracks Shift/Ctrl/Alt state.
module ps2_kbd_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1000000
) (
    input  logic                              CLOCK,
    input  logic                              RESET,
    input  logic [7:0]                        RX_DATA,
    input  logic                              DATA_VALID,
    output logic [7:0]                        KEY_CODE,
    output logic                              KEY_EXT,
    output logic                              KEY_BREAK,
    output logic                              KEY_VALID,
    input  logic                              KEY_READ,
    output logic                              MOD_SHIFT,
    output logic                              MOD_CTRL,
    output logic                              MOD_ALT,
    output logic                              OVERFLOW,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   FIFO_COUNT
);

    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int TCW = ($clog2(TIMEOUT + 1) > 20) ? $clog2(TIMEOUT + 1) : 20;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_E0   = 2'd1,
        S_F0   = 2'd2,
        S_E0F0 = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [TCW-1:0]  tcnt_q, tcnt_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            lshift_q, lshift_d;
    logic            rshift_q, rshift_d;
    logic            ctrl_q, ctrl_d;
    logic            alt_q, alt_d;
    logic [9:0]      mem_q [FIFO_DEPTH];

    logic            is_status, is_e0, is_f0, tmo;
    logic            emit, emit_ext, emit_brk;
    logic            full, pop, push;
    logic [9:0]      head;

    always_comb begin
        is_e0     = (RX_DATA == 8'hE0);
        is_f0     = (RX_DATA == 8'hF0);
        is_status = (RX_DATA == 8'h00) || (RX_DATA == 8'hAA) ||
                    (RX_DATA == 8'hEE) || (RX_DATA == 8'hFA) ||
                    (RX_DATA == 8'hFE) || (RX_DATA == 8'hFF) ||
                    (RX_DATA == 8'hE1);
        // A byte arriving in the expiry cycle wins over the timeout
        tmo = (state_q != S_IDLE) && !DATA_VALID &&
              (tcnt_q == TCW'(TIMEOUT - 1));
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (DATA_VALID) begin
            if (is_status) begin
                state_d = S_IDLE;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (is_e0)      state_d = S_E0;
                        else if (is_f0) state_d = S_F0;
                        else            state_d = S_IDLE;
                    end
                    S_E0: begin
                        if (is_f0)      state_d = S_E0F0;
                        else if (is_e0) state_d = S_E0;
                        else            state_d = S_IDLE;
                    end
                    S_F0: begin
                        if (is_e0 || is_f0) state_d = S_F0;
                        else                state_d = S_IDLE;
                    end
                    S_E0F0: begin
                        if (is_e0 || is_f0) state_d = S_E0F0;
                        else                state_d = S_IDLE;
                    end
                endcase
            end
        end else if (tmo) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        if (DATA_VALID || tmo || state_q == S_IDLE) tcnt_d = '0;
        else                                        tcnt_d = tcnt_q + TCW'(1);
    end

    always_comb begin
        emit     = DATA_VALID && !is_status && !is_e0 && !is_f0;
        emit_ext = 1'b0;
        emit_brk = 1'b0;
        unique case (state_q)
            S_IDLE: ;
            S_E0:   emit_ext = 1'b1;
            S_F0:   emit_brk = 1'b1;
            S_E0F0: begin
                emit_ext = 1'b1;
                emit_brk = 1'b1;
            end
        endcase
    end

    always_comb begin
        lshift_d = lshift_q;
        rshift_d = rshift_q;
        ctrl_d   = ctrl_q;
        alt_d    = alt_q;
        if (emit) begin
            if (RX_DATA == 8'h12 && !emit_ext) lshift_d = !emit_brk;
            if (RX_DATA == 8'h59 && !emit_ext) rshift_d = !emit_brk;
            if (RX_DATA == 8'h14)              ctrl_d   = !emit_brk;
            if (RX_DATA == 8'h11)              alt_d    = !emit_brk;
        end
    end

    always_comb begin
        full     = (count_q == CW'(FIFO_DEPTH));
        pop      = KEY_READ && (count_q != '0);
        // A pop in the same cycle frees the slot the new event needs
        push     = emit && (!full || pop);
        ovf_d    = ovf_q || (emit && full && !pop);
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            lshift_q <= 1'b0;
            rshift_q <= 1'b0;
            ctrl_q   <= 1'b0;
            alt_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            lshift_q <= lshift_d;
            rshift_q <= rshift_d;
            ctrl_q   <= ctrl_d;
            alt_q    <= alt_d;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET && push) mem_q[wr_ptr_q] <= {emit_ext, emit_brk, RX_DATA};
    end

    always_comb begin
        head       = mem_q[rd_ptr_q];
        KEY_VALID  = (count_q != '0);
        KEY_CODE   = KEY_VALID ? head[7:0] : 8'h00;
        KEY_BREAK  = KEY_VALID && head[8];
        KEY_EXT    = KEY_VALID && head[9];
        MOD_SHIFT  = lshift_q || rshift_q;
        MOD_CTRL   = ctrl_q;
        MOD_ALT    = alt_q;
        OVERFLOW   = ovf_q;
        FIFO_COUNT = count_q;
    end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Bench for ps2_kbd_ctrl: directed plan steps, then random byte traffic
// checked every cycle against a prefix-flag/queue reference model.
module tb_ps2_kbd_ctrl;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b0;
    logic [7:0] RX_DATA = 8'h00;
    logic       DATA_VALID = 1'b0;
    logic       KEY_READ = 1'b0;
    logic [7:0] KEY_CODE;
    logic       KEY_EXT, KEY_BREAK, KEY_VALID;
    logic       MOD_SHIFT, MOD_CTRL, MOD_ALT, OVERFLOW;
    logic [2:0] FIFO_COUNT;

    int total = 0;
    int bad   = 0;

    logic [9:0] mq[$];
    bit  m_ext, m_brk, m_lsh, m_rsh, m_ctl, m_alt, m_ovf;
    int  m_wait;

    logic [7:0] stat_tab [7] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF, 8'hE1};
    logic [7:0] mod_tab  [4] = '{8'h12, 8'h59, 8'h14, 8'h11};

    ps2_kbd_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .RX_DATA(RX_DATA),
        .DATA_VALID(DATA_VALID), .KEY_CODE(KEY_CODE), .KEY_EXT(KEY_EXT),
        .KEY_BREAK(KEY_BREAK), .KEY_VALID(KEY_VALID), .KEY_READ(KEY_READ),
        .MOD_SHIFT(MOD_SHIFT), .MOD_CTRL(MOD_CTRL), .MOD_ALT(MOD_ALT),
        .OVERFLOW(OVERFLOW), .FIFO_COUNT(FIFO_COUNT)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_status(input logic [7:0] b);
        foreach (stat_tab[i]) if (stat_tab[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    // Reference: pending-prefix flags plus an event queue
    task automatic model(input bit dv, input logic [7:0] b,
                         input bit rd, input bit rst);
        logic [9:0] ev;
        bit emit, pop;
        int sz;
        if (rst) begin
            mq.delete();
            {m_ext, m_brk, m_lsh, m_rsh, m_ctl, m_alt, m_ovf} = '0;
            m_wait = 0;
            return;
        end
        emit = 1'b0;
        ev = '0;
        if (dv) begin
            m_wait = 0;
            if (is_status(b)) begin
                m_ext = 0; m_brk = 0;
            end else if (b == 8'hE0) begin
                if (!m_brk) m_ext = 1;
            end else if (b == 8'hF0) begin
                m_brk = 1;
            end else begin
                emit = 1'b1;
                ev = {m_ext, m_brk, b};
                m_ext = 0; m_brk = 0;
            end
        end else if (m_ext || m_brk) begin
            m_wait++;
            if (m_wait >= TMO) begin
                m_ext = 0; m_brk = 0; m_wait = 0;
            end
        end
        sz  = mq.size();
        pop = rd && sz > 0;
        if (pop) void'(mq.pop_front());
        if (emit) begin
            if (sz < DEPTH || pop) mq.push_back(ev);
            else m_ovf = 1;
            if (ev[7:0] == 8'h12 && !ev[9]) m_lsh = !ev[8];
            if (ev[7:0] == 8'h59 && !ev[9]) m_rsh = !ev[8];
            if (ev[7:0] == 8'h14) m_ctl = !ev[8];
            if (ev[7:0] == 8'h11) m_alt = !ev[8];
        end
    endtask

    task automatic check_all();
        logic [9:0] h;
        h = (mq.size() != 0) ? mq[0] : 10'h0;
        chk("valid", 32'(KEY_VALID), 32'(mq.size() != 0));
        chk("code",  32'(KEY_CODE),  32'(h[7:0]));
        chk("brk",   32'(KEY_BREAK), 32'(h[8]));
        chk("ext",   32'(KEY_EXT),   32'(h[9]));
        chk("shift", 32'(MOD_SHIFT), 32'(m_lsh | m_rsh));
        chk("ctrl",  32'(MOD_CTRL),  32'(m_ctl));
        chk("alt",   32'(MOD_ALT),   32'(m_alt));
        chk("ovf",   32'(OVERFLOW),  32'(m_ovf));
        chk("count", 32'(FIFO_COUNT), 32'(mq.size()));
    endtask

    task automatic step(input bit dv, input logic [7:0] b,
                        input bit rd, input bit rst);
        RESET = rst; DATA_VALID = dv; RX_DATA = b; KEY_READ = rd;
        @(posedge CLOCK);
        model(dv, b, rd, rst);
        @(negedge CLOCK);
        RESET = 0; DATA_VALID = 0; KEY_READ = 0; RX_DATA = 8'h00;
        check_all();
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic head_is(input string tag, input logic [9:0] exp);
        chk(tag, 32'({KEY_EXT, KEY_BREAK, KEY_CODE}), 32'(exp));
    endtask

    initial begin
        logic [7:0] b;
        int r;
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("rst_count", 32'(FIFO_COUNT), 0);
        chk("rst_valid", 32'(KEY_VALID), 0);

        send(8'h1C);
        head_is("make_1c", 10'h01C);
        chk("make_valid", 32'(KEY_VALID), 1);
        pop();
        chk("make_pop", 32'(FIFO_COUNT), 0);

        send(8'hE0); send(8'hF0);
        chk("pfx_noevt", 32'(KEY_VALID), 0);
        send(8'h75);
        head_is("ext_brk", 10'h375);
        pop();

        send(8'h12); send(8'h59); send(8'hF0); send(8'h12);
        chk("shift_hold", 32'(MOD_SHIFT), 1);
        head_is("mod_e0", 10'h012);
        pop(); head_is("mod_e1", 10'h059);
        pop(); head_is("mod_e2", 10'h112);
        pop();
        send(8'hF0); send(8'h59);
        chk("shift_rel", 32'(MOD_SHIFT), 0);
        send(8'hE0); send(8'h14);
        chk("ctrl_ext", 32'(MOD_CTRL), 1);
        head_is("mod_e3", 10'h159);
        pop(); head_is("mod_e4", 10'h214);
        pop();

        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) send(8'h15 + 8'(i));
        chk("ovf_count", 32'(FIFO_COUNT), 4);
        chk("ovf_flag", 32'(OVERFLOW), 1);
        head_is("ovf_head", 10'h015);
        step(1'b1, 8'h1A, 1'b1, 1'b0);
        chk("full_pp_count", 32'(FIFO_COUNT), 4);
        head_is("full_pp_head", 10'h016);
        repeat (4) pop();

        step(1'b0, 8'h00, 1'b0, 1'b1);
        send(8'hE0); idle(20); send(8'h1C);
        head_is("tmo_plain", 10'h01C);
        pop();
        send(8'hF0); send(8'hFA); send(8'h1C);
        head_is("status_drop", 10'h01C);
        pop();
        send(8'hE0); idle(TMO - 1); send(8'h1C);
        head_is("tmo_edge_in", 10'h21C);
        pop();
        send(8'hE0); idle(TMO); send(8'h1C);
        head_is("tmo_edge_out", 10'h01C);
        pop();

        send(8'h11); send(8'h1C); send(8'hE0); send(8'hF0);
        chk("pre_rst_alt", 32'(MOD_ALT), 1);
        chk("pre_rst_cnt", 32'(FIFO_COUNT), 2);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("rst_all", 32'({KEY_VALID, KEY_CODE, KEY_EXT, KEY_BREAK,
            MOD_SHIFT, MOD_CTRL, MOD_ALT, OVERFLOW, FIFO_COUNT}), 0);
        send(8'h6B);
        head_is("post_rst", 10'h06B);
        pop();

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      b = 8'hE0;
            else if (r == 1) b = 8'hF0;
            else if (r == 2) b = stat_tab[$urandom_range(0, 6)];
            else if (r <= 4) b = mod_tab[$urandom_range(0, 3)];
            else             b = 8'($urandom_range(0, 255));
            step($urandom_range(0, 9) < 6, b, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 199) == 0);
            if ($urandom_range(0, 40) == 0) idle($urandom_range(TMO - 2, TMO + 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
